// File: rtl/operand_prep_pkg.sv
// Shared adder package: FSM state encoding, canonical quiet-NaN builder and
// IEEE-style field-extraction helpers.
// The helpers work on a FIELD_W-bit container so one set of functions serves
// any EXPBITS/MANTISSABITS combination up to FIELD_W total bits. Callers
// zero-extend the operand in and truncate the result back to field width.
package operand_prep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COMPARE,
    ST_ISSUE,
    ST_SPECIAL,
    ST_BUSY
  } state_t;

  localparam int unsigned FIELD_W = 64;
  typedef logic [FIELD_W-1:0] field_t;

  function automatic logic fp_sign(input field_t x, input int unsigned eb,
                                   input int unsigned mb);
    field_t t;
    t = x >> (eb + mb);
    return t[0];
  endfunction

  function automatic field_t fp_exp(input field_t x, input int unsigned eb,
                                    input int unsigned mb);
    field_t mask;
    mask = (field_t'(1) << eb) - field_t'(1);
    return (x >> mb) & mask;
  endfunction

  function automatic field_t fp_frac(input field_t x, input int unsigned mb);
    field_t mask;
    mask = (field_t'(1) << mb) - field_t'(1);
    return x & mask;
  endfunction

  // {0, exponent all ones, fraction MSB set, rest zero}
  function automatic field_t fp_qnan(input int unsigned eb, input int unsigned mb);
    field_t r;
    r = ((field_t'(1) << eb) - field_t'(1)) << mb;
    r = r | (field_t'(1) << (mb - 1));
    return r;
  endfunction

endpackage

// File: rtl/operand_prep_classify.sv
// operand_classify: combinational zero / infinity / NaN flags for one
// IEEE-style operand. A zero exponent counts as zero (denormals flushed).
// Ports:
//   Op     in  WIDTH  operand {sign, exponent, fraction}
//   IsZero out 1      exponent is zero
//   IsInf  out 1      exponent all ones, fraction zero
//   IsNaN  out 1      exponent all ones, fraction nonzero
module operand_classify
  import operand_prep_pkg::*;
#(
  parameter int unsigned EXPBITS      = 8,
  parameter int unsigned MANTISSABITS = 23,
  localparam int unsigned WIDTH       = 1 + EXPBITS + MANTISSABITS
) (
  input  logic [WIDTH-1:0] Op,
  output logic             IsZero,
  output logic             IsInf,
  output logic             IsNaN
);

  field_t exp_f;
  field_t frac_f;
  logic   exp_ones;

  assign exp_f    = fp_exp(field_t'(Op), EXPBITS, MANTISSABITS);
  assign frac_f   = fp_frac(field_t'(Op), MANTISSABITS);
  assign exp_ones = (exp_f == ((field_t'(1) << EXPBITS) - field_t'(1)));

  assign IsZero = (exp_f == '0);
  assign IsInf  = exp_ones && (frac_f == '0);
  assign IsNaN  = exp_ones && (frac_f != '0);

endmodule

// File: rtl/operand_prep.sv
// operand_prep: captures an A/B operand pair, orders it by exponent, restores
// hidden bits and resolves special cases before handing off to the adder
// control stage.
// Ports:
//   Clock, Reset            clock, asynchronous active-high reset
//   InValid / InReady       operand-pair handshake (ready only in IDLE)
//   A, B                    operands {sign, exponent, fraction}
//   Go                      one-cycle start pulse to the adder control stage
//   ExpSet, ExpDiff, BigExp operand ordering and exponent difference
//   ManBig, ManSmall        mantissas with hidden bit, after the swap
//   SignBig, SignSmall      signs after the swap
//   Special, SpecialResult  one-cycle bypass pulse and its result
//   Done                    downstream finished (honoured only in BUSY)
module operand_prep
  import operand_prep_pkg::*;
#(
  parameter int unsigned EXPBITS      = 8,
  parameter int unsigned MANTISSABITS = 23,
  localparam int unsigned WIDTH       = 1 + EXPBITS + MANTISSABITS
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [WIDTH-1:0]        A,
  input  logic [WIDTH-1:0]        B,
  output logic                    Go,
  output logic                    ExpSet,
  output logic [EXPBITS-1:0]      ExpDiff,
  output logic [EXPBITS-1:0]      BigExp,
  output logic [MANTISSABITS:0]   ManBig,
  output logic [MANTISSABITS:0]   ManSmall,
  output logic                    SignBig,
  output logic                    SignSmall,
  output logic                    Special,
  output logic [WIDTH-1:0]        SpecialResult,
  input  logic                    Done
);

  localparam field_t QNAN_F = fp_qnan(EXPBITS, MANTISSABITS);
  localparam logic [WIDTH-1:0] QNAN = QNAN_F[WIDTH-1:0];

  state_t                  state_q;
  logic [WIDTH-1:0]        a_q, b_q;
  logic                    ready_q, go_q, special_q;
  logic                    exp_set_q, sign_big_q, sign_small_q;
  logic [EXPBITS-1:0]      exp_diff_q, big_exp_q;
  logic [MANTISSABITS:0]   man_big_q, man_small_q;
  logic [WIDTH-1:0]        special_result_q;

  logic [EXPBITS-1:0]      exp_a, exp_b;
  logic [MANTISSABITS-1:0] frac_a, frac_b;
  logic                    sign_a, sign_b;
  logic                    a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

  logic                    exp_set_d, sign_big_d, sign_small_d, special_d;
  logic [EXPBITS-1:0]      exp_diff_d, big_exp_d;
  logic [MANTISSABITS:0]   man_a, man_b, man_big_d, man_small_d;
  logic [WIDTH-1:0]        special_result_d;
  logic [EXPBITS:0]        diff_wide;
  logic                    diff_unused;

  assign exp_a  = EXPBITS'(fp_exp(field_t'(a_q), EXPBITS, MANTISSABITS));
  assign exp_b  = EXPBITS'(fp_exp(field_t'(b_q), EXPBITS, MANTISSABITS));
  assign frac_a = MANTISSABITS'(fp_frac(field_t'(a_q), MANTISSABITS));
  assign frac_b = MANTISSABITS'(fp_frac(field_t'(b_q), MANTISSABITS));
  assign sign_a = fp_sign(field_t'(a_q), EXPBITS, MANTISSABITS);
  assign sign_b = fp_sign(field_t'(b_q), EXPBITS, MANTISSABITS);

  operand_classify #(.EXPBITS(EXPBITS), .MANTISSABITS(MANTISSABITS)) u_class_a (
    .Op(a_q), .IsZero(a_zero), .IsInf(a_inf), .IsNaN(a_nan)
  );

  operand_classify #(.EXPBITS(EXPBITS), .MANTISSABITS(MANTISSABITS)) u_class_b (
    .Op(b_q), .IsZero(b_zero), .IsInf(b_inf), .IsNaN(b_nan)
  );

  // Zero exponent flushes the whole mantissa, not just the hidden bit.
  assign man_a = (exp_a != '0) ? {1'b1, frac_a} : '0;
  assign man_b = (exp_b != '0) ? {1'b1, frac_b} : '0;

  always_comb begin
    exp_set_d = (exp_a >= exp_b);
    // Subtraction is done one bit wider and always as big minus small, so the
    // carry-out is always zero and the result never wraps.
    diff_wide = exp_set_d ? ({1'b0, exp_a} - {1'b0, exp_b})
                          : ({1'b0, exp_b} - {1'b0, exp_a});
    {diff_unused, exp_diff_d} = diff_wide;
    big_exp_d    = exp_set_d ? exp_a  : exp_b;
    man_big_d    = exp_set_d ? man_a  : man_b;
    man_small_d  = exp_set_d ? man_b  : man_a;
    sign_big_d   = exp_set_d ? sign_a : sign_b;
    sign_small_d = exp_set_d ? sign_b : sign_a;

    special_d        = 1'b1;
    special_result_d = QNAN;
    if (a_nan || b_nan) begin
      special_result_d = QNAN;
    end else if (a_inf && b_inf && (sign_a != sign_b)) begin
      special_result_d = QNAN;
    end else if (a_inf) begin
      special_result_d = a_q;
    end else if (b_inf) begin
      special_result_d = b_q;
    end else if (a_zero && b_zero) begin
      special_result_d = {sign_a & sign_b, {(WIDTH-1){1'b0}}};
    end else if (a_zero) begin
      special_result_d = b_q;
    end else if (b_zero) begin
      special_result_d = a_q;
    end else begin
      special_d        = 1'b0;
      special_result_d = '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q          <= ST_IDLE;
      a_q              <= '0;
      b_q              <= '0;
      ready_q          <= 1'b1;
      go_q             <= 1'b0;
      special_q        <= 1'b0;
      exp_set_q        <= 1'b0;
      exp_diff_q       <= '0;
      big_exp_q        <= '0;
      man_big_q        <= '0;
      man_small_q      <= '0;
      sign_big_q       <= 1'b0;
      sign_small_q     <= 1'b0;
      special_result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (InValid) begin
            a_q     <= A;
            b_q     <= B;
            ready_q <= 1'b0;
            state_q <= ST_COMPARE;
          end
        end
        ST_COMPARE: begin
          exp_set_q        <= exp_set_d;
          exp_diff_q       <= exp_diff_d;
          big_exp_q        <= big_exp_d;
          man_big_q        <= man_big_d;
          man_small_q      <= man_small_d;
          sign_big_q       <= sign_big_d;
          sign_small_q     <= sign_small_d;
          special_result_q <= special_result_d;
          if (special_d) begin
            special_q <= 1'b1;
            state_q   <= ST_SPECIAL;
          end else begin
            go_q    <= 1'b1;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          go_q    <= 1'b0;
          state_q <= ST_BUSY;
        end
        ST_SPECIAL: begin
          special_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        ST_BUSY: begin
          if (Done) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          go_q      <= 1'b0;
          special_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign InReady       = ready_q;
  assign Go            = go_q;
  assign Special       = special_q;
  assign ExpSet        = exp_set_q;
  assign ExpDiff       = exp_diff_q;
  assign BigExp        = big_exp_q;
  assign ManBig        = man_big_q;
  assign ManSmall      = man_small_q;
  assign SignBig       = sign_big_q;
  assign SignSmall     = sign_small_q;
  assign SpecialResult = special_result_q;

endmodule

// File: tb/tb_operand_prep.sv
module tb_operand_prep;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] A, B;
  logic        Go, ExpSet, SignBig, SignSmall, Special, Done;
  logic [7:0]  ExpDiff, BigExp;
  logic [23:0] ManBig, ManSmall;
  logic [31:0] SpecialResult;

  int vectors    = 0;
  int miscompares = 0;

  operand_prep #(.EXPBITS(8), .MANTISSABITS(23)) dut (
    .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .Go(Go), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
    .BigExp(BigExp), .ManBig(ManBig), .ManSmall(ManSmall),
    .SignBig(SignBig), .SignSmall(SignSmall), .Special(Special),
    .SpecialResult(SpecialResult), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    bit          sp;
    logic [31:0] sr;
    bit          es;
    logic [7:0]  ed;
    logic [7:0]  be;
    logic [23:0] mb;
    logic [23:0] ms;
    bit          sgb;
    bit          sgs;
  } exp_t;

  // Reference: single-precision rules evaluated with plain integer arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t m;
    int unsigned ea, eb, fa, fb;
    bit sa, sb, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    ea = (a >> 23) % 256; eb = (b >> 23) % 256;
    fa = a % (1 << 23);   fb = b % (1 << 23);
    sa = a[31];           sb = b[31];
    nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
    z_a = (ea == 0); z_b = (eb == 0);
    m.sp = 1'b1;
    if (nan_a || nan_b)                   m.sr = 32'h7FC0_0000;
    else if (inf_a && inf_b && sa != sb)  m.sr = 32'h7FC0_0000;
    else if (inf_a)                       m.sr = a;
    else if (inf_b)                       m.sr = b;
    else if (z_a && z_b)                  m.sr = (sa && sb) ? 32'h8000_0000 : 32'h0;
    else if (z_a)                         m.sr = b;
    else if (z_b)                         m.sr = a;
    else begin m.sp = 1'b0; m.sr = 32'h0; end
    m.es = (ea >= eb);
    m.ed = 8'(m.es ? ea - eb : eb - ea);
    m.be = 8'(m.es ? ea : eb);
    m.mb = 24'(m.es ? (ea == 0 ? 0 : (1 << 23) + fa) : (eb == 0 ? 0 : (1 << 23) + fb));
    m.ms = 24'(m.es ? (eb == 0 ? 0 : (1 << 23) + fb) : (ea == 0 ? 0 : (1 << 23) + fa));
    m.sgb = m.es ? sa : sb;
    m.sgs = m.es ? sb : sa;
    return m;
  endfunction

  function automatic logic [31:0] rand_op();
    int unsigned sel, e, f;
    sel = $urandom_range(0, 9);
    e = (sel == 0) ? 0 : (sel == 1) ? 255 : $urandom_range(1, 254);
    f = ($urandom_range(0, 3) == 0) ? 0 : ($urandom % (1 << 23));
    return {1'($urandom_range(0, 1)), 8'(e), 23'(f)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_data(input string tag, input exp_t m);
    chk({tag, "_expset"},   64'(ExpSet),    64'(m.es));
    chk({tag, "_expdiff"},  64'(ExpDiff),   64'(m.ed));
    chk({tag, "_bigexp"},   64'(BigExp),    64'(m.be));
    chk({tag, "_manbig"},   64'(ManBig),    64'(m.mb));
    chk({tag, "_mansmall"}, 64'(ManSmall),  64'(m.ms));
    chk({tag, "_signbig"},  64'(SignBig),   64'(m.sgb));
    chk({tag, "_signsmall"},64'(SignSmall), 64'(m.sgs));
  endtask

  // Called just after the capture edge; walks COMPARE, ISSUE/SPECIAL and the
  // following cycle.
  task automatic after_capture(input logic [31:0] a, input logic [31:0] b, output exp_t m);
    m = model(a, b);
    chk("cmp_ready",   64'(InReady), 64'd0);
    chk("cmp_go",      64'(Go),      64'd0);
    chk("cmp_special", 64'(Special), 64'd0);
    tick();
    if (m.sp) begin
      chk("sp_pulse",  64'(Special),       64'd1);
      chk("sp_go",     64'(Go),            64'd0);
      chk("sp_result", 64'(SpecialResult), 64'(m.sr));
    end else begin
      chk("issue_go",      64'(Go),      64'd1);
      chk("issue_special", 64'(Special), 64'd0);
    end
    check_data("out", m);
    tick();
    chk("post_go",      64'(Go),      64'd0);
    chk("post_special", 64'(Special), 64'd0);
    chk("post_ready",   64'(InReady), m.sp ? 64'd1 : 64'd0);
  endtask

  task automatic issue_pair(input logic [31:0] a, input logic [31:0] b, output exp_t m);
    for (int i = 0; i < 20; i++) begin
      if (InReady) break;
      tick();
    end
    chk("wait_ready", 64'(InReady), 64'd1);
    InValid = 1'b1; A = a; B = b;
    tick();
    InValid = 1'b0; A = $urandom; B = $urandom;
    after_capture(a, b, m);
  endtask

  task automatic release_busy(input int n, input exp_t m);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("busy_ready", 64'(InReady), 64'd0);
      chk("busy_go",    64'(Go),      64'd0);
      chk("busy_manbig", 64'(ManBig), 64'(m.mb));
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("done_ready", 64'(InReady), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m, m2;
    logic [31:0] ra, rb;

    Reset = 1'b1; InValid = 1'b0; Done = 1'b0; A = '0; B = '0;
    #1;
    chk("rst_ready", 64'(InReady), 64'd1);
    chk("rst_outs", {Go, Special, ExpSet, SignBig, SignSmall, ExpDiff, BigExp},
        64'd0);
    chk("rst_mans", {ManBig, ManSmall}, 64'd0);
    chk("rst_sres", 64'(SpecialResult), 64'd0);
    tick();
    Reset = 1'b0;

    // Normal ordering, then swapped ordering.
    issue_pair(32'h4040_0000, 32'h3F80_0000, m);
    chk("d1_manbig", 64'(ManBig), 64'hC0_0000);
    chk("d1_expdiff", 64'(ExpDiff), 64'd1);
    release_busy(2, m);
    issue_pair(32'h3F80_0000, 32'h4040_0000, m);
    chk("d2_expset", 64'(ExpSet), 64'd0);
    chk("d2_manbig", 64'(ManBig), 64'hC0_0000);
    release_busy(0, m);

    // Specials: +Inf + -Inf, signed zeros, one zero.
    issue_pair(32'h7F80_0000, 32'hFF80_0000, m);
    chk("d3_qnan", 64'(m.sr), 64'h7FC0_0000);
    issue_pair(32'h8000_0000, 32'h8000_0000, m);
    issue_pair(32'h0000_0000, 32'h3F80_0000, m);

    // New pair held during BUSY must not be taken until IDLE.
    issue_pair(32'hC1A0_0000, 32'h4120_0000, m);
    InValid = 1'b1; A = 32'h3FC0_0000; B = 32'hBF00_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ready", 64'(InReady), 64'd0);
      check_data("hold", m);
    end
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("hold_idle", 64'(InReady), 64'd1);
    tick();
    InValid = 1'b0;
    after_capture(32'h3FC0_0000, 32'hBF00_0000, m2);
    release_busy(1, m2);

    // Asynchronous reset in BUSY, then Done after reset is ignored.
    issue_pair(32'h4248_0000, 32'h4000_0000, m);
    #3 Reset = 1'b1;
    #1;
    chk("arst_ready", 64'(InReady), 64'd1);
    chk("arst_outs", {Go, Special, ExpSet, SignBig, SignSmall, ExpDiff, BigExp},
        64'd0);
    chk("arst_mans", {ManBig, ManSmall}, 64'd0);
    chk("arst_sres", 64'(SpecialResult), 64'd0);
    #1 Reset = 1'b0;
    Done = 1'b1;
    tick();
    Done = 1'b0;
    chk("arst_done_ready", 64'(InReady), 64'd1);
    chk("arst_done_go", 64'(Go), 64'd0);

    // First edge after reset release must capture.
    Reset = 1'b1;
    #2 Reset = 1'b0;
    InValid = 1'b1; A = 32'h4080_0000; B = 32'h4080_0000;
    tick();
    InValid = 1'b0;
    after_capture(32'h4080_0000, 32'h4080_0000, m);
    release_busy(1, m);

    // Randomised pairs, with frequent exponent ties and special classes.
    for (int n = 0; n < 40; n++) begin
      ra = rand_op();
      rb = rand_op();
      if ($urandom_range(0, 3) == 0) rb[30:23] = ra[30:23];
      issue_pair(ra, rb, m);
      if (!m.sp) release_busy($urandom_range(0, 3), m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_prep.md
OPERAND_PREP -- requirements
Module: operand_prep

Interface
REQ-001 Parameters SHALL be: EXPBITS, default 8, exponent width; MANTISSABITS, default 23, stored fraction width; WIDTH = 1+EXPBITS+MANTISSABITS is derived and is not overridable.
REQ-002 Ports SHALL be, one per line:
  Clock  in  1  single clock; all state changes on its rising edge.
  Reset  in  1  asynchronous, active-high reset.
  InValid  in  1  operand pair A/B presented.
  InReady  out  1  block can accept an operand pair.
  A  in  WIDTH  IEEE-style operand {sign, exponent, fraction}.
  B  in  WIDTH  IEEE-style operand.
  Go  out  1  one-cycle start pulse to the adder control stage.
  ExpSet  out  1  1 when ExpA >= ExpB, i.e. A is the big operand.
  ExpDiff  out  EXPBITS  |ExpA - ExpB|.
  BigExp  out  EXPBITS  exponent of the big operand.
  ManBig  out  MANTISSABITS+1  big-operand mantissa with the hidden bit.
  ManSmall  out  MANTISSABITS+1  small-operand mantissa with the hidden bit.
  SignBig, SignSmall  out  1 each  operand signs after the swap.
  Special  out  1  one-cycle pulse: result bypasses the datapath.
  SpecialResult  out  WIDTH  bypass result; valid while Special=1.
  Done  in  1  downstream has finished the current operation.

Function
REQ-003 The FSM SHALL have states IDLE, COMPARE, ISSUE, SPECIAL and BUSY.
REQ-004 InReady SHALL be 1 only in IDLE; the pair is captured on the edge where InValid&InReady=1, and the state becomes COMPARE.
REQ-005 COMPARE SHALL register every data output, then go to SPECIAL if the pair is a special case, otherwise to ISSUE.
REQ-006 ISSUE SHALL drive Go=1 for exactly one cycle and then go to BUSY; Go therefore rises one clock after the capture edge.
REQ-007 BUSY SHALL hold every data output stable and go to IDLE on the first edge where Done=1; Done SHALL be ignored in every other state.
REQ-008 SPECIAL SHALL drive Special=1 for exactly one cycle with Go=0, then go to IDLE.
REQ-009 Operand selection: ExpSet=1 if ExpA >= ExpB; a tie SHALL select A as the big operand; the Big outputs SHALL take the selected operand and the Small outputs the other.
REQ-010 The hidden bit SHALL be 1 when the exponent is nonzero; an operand with a zero exponent SHALL be treated as zero (denormals are flushed).
REQ-011 ExpDiff SHALL be computed at EXPBITS+1 bits internally and never wrap; with ExpSet=1 it is ExpA-ExpB, otherwise ExpB-ExpA.
REQ-012 Special cases SHALL be resolved in this priority order:
  (1) Either operand NaN (exponent all ones, fraction nonzero) -> canonical qNaN {0, all ones, 1, zeros}.
  (2) +Inf plus -Inf -> canonical qNaN.
  (3) One or both Inf -> that Inf.
  (4) Both zero -> sign = SignA & SignB, magnitude zero.
  (5) Exactly one zero -> the other operand unchanged.
REQ-013 InValid seen outside IDLE SHALL NOT be captured, and A/B SHALL be ignored.

Reset
REQ-014 Reset=1 SHALL immediately force IDLE, InReady=1, and Go, Special, ExpSet, ExpDiff, BigExp, ManBig, ManSmall, SignBig, SignSmall and SpecialResult all to 0; this holds in any state, including mid-BUSY.
REQ-015 After Reset deasserts, the first capture SHALL be possible on the first rising edge.

Structure
REQ-016 The FSM state enum, the canonical qNaN constant and the operand field-extraction helpers SHALL live in the shared adder package.
REQ-017 Classification (zero/inf/NaN flags per operand) SHALL be a combinational sub-module named operand_classify, instantiated once per operand.

Verification
REQ-018 Capture A=0x40400000, B=0x3F800000 -> ExpSet=1, ExpDiff=1, BigExp=0x80, ManBig=0xC00000, ManSmall=0x800000, and Go high exactly 1 cycle, one clock after capture.
REQ-019 Capture A=0x3F800000, B=0x40400000 -> ExpSet=0, ExpDiff=1, ManBig=0xC00000, SignBig=0.
REQ-020 Capture A=0x7F800000, B=0xFF800000 -> Special pulse with SpecialResult=0x7FC00000, Go never asserted, InReady=1 the following cycle.
REQ-021 Capture A=0x80000000, B=0x80000000 -> SpecialResult=0x80000000; then capture A=0x00000000, B=0x3F800000 -> SpecialResult=0x3F800000.
REQ-022 Hold InValid=1 with new A/B during BUSY -> InReady=0, outputs unchanged; Done=1 -> IDLE on the next edge, then the new pair is captured.
REQ-023 Assert Reset asynchronously mid-BUSY -> all outputs 0 and InReady=1 before the next clock edge; Done pulses after Reset deasserts -> no effect.
